read_last_tracker: RTL and testbench

READ_LAST_TRACKER -- requirements
Module: read_last_tracker

---
 rtl/read_last_tracker.sv | 91 +++++++++
 tb/tb_read_last_tracker.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/read_last_tracker.sv
// Tracks which PHY read segments close an AXI transaction and masks r_last on the rest.
// R channel passes through with zero latency; reads stall upstream while Depth segments are outstanding.
module read_last_tracker #(
   parameter int DataWidth = 64,
   parameter int Depth     = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       cmd_valid_i,
   output logic                       cmd_ready_o,
   output logic                       cmd_valid_o,
   input  logic                       cmd_ready_i,
   input  logic                       is_write_i,
   input  logic                       seg_final_i,
   input  logic [DataWidth-1:0]       r_data_i,
   output logic [DataWidth-1:0]       r_data_o,
   input  logic                       r_valid_i,
   output logic                       r_valid_o,
   input  logic                       r_ready_i,
   output logic                       r_ready_o,
   input  logic                       r_last_i,
   output logic                       r_last_o,
   output logic [$clog2(Depth):0]     pending_o,
   output logic                       err_o
);

   localparam int PtrW = $clog2(Depth);
   localparam int CntW = PtrW + 1;

   logic [Depth-1:0] r_fifo;
   logic [PtrW-1:0]  r_wptr;
   logic [PtrW-1:0]  r_rptr;
   logic [CntW-1:0]  r_pending;
   logic             r_err;

   logic w_full;
   logic w_empty;
   logic w_rd_blk;
   logic w_push;
   logic w_beat;
   logic w_pop;
   logic w_orphan;

   assign w_full   = (r_pending == CntW'(Depth));
   assign w_empty  = (r_pending == '0);
   // Writes are never tracked, so a full tracker only blocks read segments.
   assign w_rd_blk = w_full & ~is_write_i;

   assign cmd_valid_o = cmd_valid_i & ~w_rd_blk;
   assign cmd_ready_o = cmd_ready_i & ~w_rd_blk;

   assign w_push   = cmd_valid_o & cmd_ready_i & ~is_write_i;
   assign w_beat   = r_valid_i & r_ready_i;
   assign w_pop    = w_beat & r_last_i & ~w_empty;
   assign w_orphan = w_beat & r_last_i & w_empty;

   assign r_data_o  = r_data_i;
   assign r_valid_o = r_valid_i;
   assign r_ready_o = r_ready_i;
   assign r_last_o  = w_empty ? r_last_i : (r_last_i & r_fifo[r_rptr]);

   assign pending_o = r_pending;
   assign err_o     = r_err;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_fifo    <= '0;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_pending <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_push) begin
            r_fifo[r_wptr] <= seg_final_i;
            r_wptr         <= r_wptr + PtrW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PtrW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_pending <= r_pending + CntW'(1);
            2'b01:   r_pending <= r_pending - CntW'(1);
            default: r_pending <= r_pending;
         endcase
         if (w_orphan) begin
            r_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_read_last_tracker.sv
// Directed bench for read_last_tracker with hand-computed expectations.
module tb_read_last_tracker;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        cmd_valid_i, cmd_ready_o, cmd_valid_o, cmd_ready_i;
   logic        is_write_i, seg_final_i;
   logic [63:0] r_data_i, r_data_o;
   logic        r_valid_i, r_valid_o, r_ready_i, r_ready_o;
   logic        r_last_i, r_last_o;
   logic [2:0]  pending_o;
   logic        err_o;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   read_last_tracker #(.DataWidth(64), .Depth(4)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
      .is_write_i(is_write_i), .seg_final_i(seg_final_i),
      .r_data_i(r_data_i), .r_data_o(r_data_o),
      .r_valid_i(r_valid_i), .r_valid_o(r_valid_o),
      .r_ready_i(r_ready_i), .r_ready_o(r_ready_o),
      .r_last_i(r_last_i), .r_last_o(r_last_o),
      .pending_o(pending_o), .err_o(err_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push_rd(input logic fin);
      cmd_valid_i = 1'b1; cmd_ready_i = 1'b1; is_write_i = 1'b0; seg_final_i = fin;
      step();
      cmd_valid_i = 1'b0; cmd_ready_i = 1'b0; seg_final_i = 1'b0;
   endtask

   task automatic do_beat(input logic last, input logic exp_lo, input string tag);
      r_valid_i = 1'b1; r_ready_i = 1'b1; r_last_i = last;
      r_data_i  = {$urandom, $urandom};
      #1;
      chk(tag, r_last_o, exp_lo);
      chk({tag, "_data"}, {r_data_o, r_valid_o, r_ready_o}, {r_data_i, 2'b11});
      step();
      r_valid_i = 1'b0; r_ready_i = 1'b0; r_last_i = 1'b0;
   endtask

   initial begin
      logic [5:0] pat;
      pat = 6'b100110;  // bit k = seg_final of segment k: 0,1,1,0,0,1

      rst_ni = 1'b0;
      cmd_valid_i = 1'b1; cmd_ready_i = 1'b1; is_write_i = 1'b0; seg_final_i = 1'b0;
      r_data_i = '0; r_valid_i = 1'b0; r_ready_i = 1'b0; r_last_i = 1'b1;
      #1;
      chk("rst_pending", pending_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_last_pass", r_last_o, 1);
      chk("rst_cmd", {cmd_valid_o, cmd_ready_o}, 2'b11);
      cmd_valid_i = 1'b0; cmd_ready_i = 1'b0; r_last_i = 1'b0;
      step();
      rst_ni = 1'b1;
      step();

      // Two-way split read, 4 beats per segment
      push_rd(1'b0);
      push_rd(1'b1);
      chk("split_pend2", pending_o, 2);
      for (int b = 1; b <= 8; b++) begin
         do_beat(b == 4 || b == 8, b == 8, $sformatf("split_beat%0d", b));
         if (b == 4) chk("split_pend1", pending_o, 1);
      end
      chk("split_pend0", pending_o, 0);
      chk("split_noerr", err_o, 0);

      // Unsplit single-beat read
      push_rd(1'b1);
      chk("unsplit_pend1", pending_o, 1);
      do_beat(1'b1, 1'b1, "unsplit_last");
      chk("unsplit_pend0", pending_o, 0);

      // Fill to Depth, then check read/write gating
      for (int i = 0; i < 4; i++) push_rd(1'b1);
      chk("full_pend4", pending_o, 4);
      cmd_valid_i = 1'b1; cmd_ready_i = 1'b1; is_write_i = 1'b0;
      #1;
      chk("full_rd_blk", {cmd_valid_o, cmd_ready_o}, 2'b00);
      is_write_i = 1'b1;
      #1;
      chk("full_wr_pass", {cmd_valid_o, cmd_ready_o}, 2'b11);
      cmd_ready_i = 1'b0;
      #1;
      chk("full_wr_rdy0", cmd_ready_o, 0);
      cmd_ready_i = 1'b1;
      step();
      chk("full_wr_nopush", pending_o, 4);
      is_write_i = 1'b0;
      r_valid_i = 1'b1; r_ready_i = 1'b1; r_last_i = 1'b1;
      #1;
      chk("full_pop_rd_blk", cmd_ready_o, 0);
      chk("full_pop_last", r_last_o, 1);
      step();
      r_valid_i = 1'b0; r_ready_i = 1'b0; r_last_i = 1'b0;
      chk("full_pend3", pending_o, 3);
      chk("full_rd_accept", cmd_ready_o, 1);
      seg_final_i = 1'b1;
      step();
      cmd_valid_i = 1'b0; cmd_ready_i = 1'b0; seg_final_i = 1'b0;
      chk("full_repend4", pending_o, 4);
      for (int i = 0; i < 4; i++) do_beat(1'b1, 1'b1, $sformatf("drain%0d", i));
      chk("drain_pend0", pending_o, 0);

      // Simultaneous push/pop with pointer wrap
      push_rd(pat[0]);
      push_rd(pat[1]);
      for (int k = 0; k < 4; k++) begin
         cmd_valid_i = 1'b1; cmd_ready_i = 1'b1; is_write_i = 1'b0; seg_final_i = pat[k+2];
         r_valid_i = 1'b1; r_ready_i = 1'b1; r_last_i = 1'b1;
         #1;
         chk($sformatf("pp_last%0d", k), r_last_o, pat[k]);
         step();
         chk($sformatf("pp_pend%0d", k), pending_o, 2);
      end
      cmd_valid_i = 1'b0; cmd_ready_i = 1'b0; seg_final_i = 1'b0;
      r_valid_i = 1'b0; r_ready_i = 1'b0; r_last_i = 1'b0;
      do_beat(1'b1, pat[4], "pp_last4");
      do_beat(1'b1, pat[5], "pp_last5");
      chk("pp_pend0", pending_o, 0);
      chk("pp_noerr", err_o, 0);

      // Orphan last sets sticky error; reset clears it
      do_beat(1'b1, 1'b1, "orphan_last");
      chk("orphan_err", err_o, 1);
      step();
      chk("orphan_err_held", err_o, 1);
      rst_ni = 1'b0;
      #1;
      chk("orphan_err_rst", err_o, 0);
      step();
      rst_ni = 1'b1;
      step();

      // Reset mid-operation drops tracked segments
      push_rd(1'b0);
      push_rd(1'b0);
      push_rd(1'b0);
      chk("mid_pend3", pending_o, 3);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_pend", pending_o, 0);
      step();
      rst_ni = 1'b1;
      step();
      do_beat(1'b1, 1'b1, "mid_last_pass");
      chk("mid_err", err_o, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
